// File: rtl/memory_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_pkg
// Purpose  : Shared types and helpers for the memory stage: access-size
//            codes, FSM state encoding, byte-lane and alignment helpers.
// Revision : 1.0 - initial release
// ============================================================================
package memory_access_pkg;

    // Access-size codes carried on PIP_mem_size_i.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    // Memory-stage FSM states.
    typedef enum logic [0:0] {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_e;

    localparam int c_wait_cnt_w = 8;

    // Byte enables for an access of the given size at the given byte offset.
    // Loads and stores use the same lane selection.
    function automatic logic [3:0] lane_enables(input logic [1:0] addr_lo,
                                                input logic [1:0] size);
        logic [3:0] be;
        be = 4'b1111;
        if (size == MEM_BYTE) begin
            be = 4'b0001 << addr_lo;
        end else if (size == MEM_HALF) begin
            be = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        return be;
    endfunction

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] size);
        return ((size == MEM_HALF) && addr_lo[0]) ||
               ((size == MEM_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_access_if
// Purpose  : Data-memory req/ack port between the memory stage (master) and
//            the data memory (slave).
// Ports    : req   - access request          we    - 1 = write
//            addr  - word-aligned address    be    - byte enables
//            wdata - lane-replicated data    ack   - access complete
//            rdata - read word, valid with ack
// Revision : 1.0 - initial release
// ============================================================================
interface memory_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_access_load_aligner.sv
`default_nettype none
// ============================================================================
// Module   : load_aligner
// Purpose  : Combinational load-data alignment: shifts the addressed bytes
//            of a read word down to bit 0, truncates to the access size and
//            sign- or zero-extends to 32 bits.
// Ports    : rdata       - raw memory word
//            addr_lo     - byte offset within the word
//            size        - MEM_BYTE / MEM_HALF / MEM_WORD
//            is_unsigned - zero-extend instead of sign-extend
//            data        - aligned, extended result
// Revision : 1.0 - initial release
// ============================================================================
module load_aligner
    import memory_access_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [1:0]  addr_lo,
    input  wire logic [1:0]  size,
    input  wire logic        is_unsigned,
    output logic      [31:0] data
);

    logic [31:0] w_shifted;
    logic        w_sign;

    assign w_shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        w_sign = 1'b0;
        data   = w_shifted;
        case (size)
            MEM_BYTE: begin
                w_sign = ~is_unsigned & w_shifted[7];
                data   = {{24{w_sign}}, w_shifted[7:0]};
            end
            MEM_HALF: begin
                w_sign = ~is_unsigned & w_shifted[15];
                data   = {{16{w_sign}}, w_shifted[15:0]};
            end
            default: begin
                data = w_shifted;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module   : memory_access
// Purpose  : Memory stage of the pipelined RISC-V core. Issues loads and
//            stores over a req/ack data-memory port, steers byte lanes,
//            traps misaligned accesses, aborts accesses that wait too long,
//            stalls upstream while a transfer is outstanding and produces
//            the MEM/WB pipeline registers.
// Ports    : clk, reset_n (async, active low)
//            PIP_*_i  - EX/MEM pipeline registers
//            dmem     - data-memory master port (memory_access_if)
//            stall_o  - holds PC, IF/ID, ID/EX and EX/MEM
//            PIP_*_o  - MEM/WB pipeline registers
// Revision : 1.0 - initial release
// ============================================================================
module memory_access
    import memory_access_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  wire logic        clk,
    input  wire logic        reset_n,

    input  wire logic        PIP_write_mem_i,
    input  wire logic        PIP_read_mem_i,
    input  wire logic [31:0] PIP_alu_result_i,
    input  wire logic [31:0] PIP_second_operand_i,
    input  wire logic [1:0]  PIP_mem_size_i,
    input  wire logic        PIP_mem_unsigned_i,
    input  wire logic        PIP_use_mem_i,
    input  wire logic        PIP_write_reg_i,
    input  wire logic [4:0]  PIP_rd_i,
    input  wire logic        PIP_TRAP_i,

    memory_access_if.master  dmem,

    output logic             stall_o,
    output logic      [31:0] PIP_alu_result_o,
    output logic      [31:0] PIP_mem_data_o,
    output logic             PIP_use_mem_o,
    output logic             PIP_write_reg_o,
    output logic      [4:0]  PIP_rd_o,
    output logic             PIP_TRAP_o
);

    // Value of the wait counter in the last cycle the request may be held.
    localparam logic [c_wait_cnt_w-1:0] c_wait_last = c_wait_cnt_w'(MAX_WAIT - 1);

    mem_state_e              r_state;
    logic [c_wait_cnt_w-1:0] r_wait_cnt;
    logic [31:0]             r_alu_result;
    logic [31:0]             r_mem_data;
    logic                    r_use_mem;
    logic                    r_write_reg;
    logic [4:0]              r_rd;
    logic                    r_trap;

    logic        w_access;
    logic        w_misaligned;
    logic        w_go;
    logic        w_at_limit;
    logic        w_timeout;
    logic        w_req;
    logic        w_stall;
    logic        w_fault;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_access     = PIP_read_mem_i | PIP_write_mem_i;
    assign w_misaligned = is_misaligned(PIP_alu_result_i[1:0], PIP_mem_size_i);

    // Gating with reset_n drops req/stall the moment reset is asserted.
    assign w_go = reset_n & w_access & ~w_misaligned;

    // The wait counter already counts the first (IDLE) request cycle, so a
    // fresh access in IDLE is at the limit only when MAX_WAIT is 1.
    assign w_at_limit = (r_state == MS_WAIT) ? (r_wait_cnt == c_wait_last)
                                             : (c_wait_last == '0);

    // An ack in the last allowed cycle completes the access instead.
    assign w_timeout = w_go & ~dmem.ack & w_at_limit;
    assign w_req     = w_go & ~w_timeout;
    assign w_stall   = w_req & ~dmem.ack;
    assign w_fault   = w_access & (w_misaligned | w_timeout);

    always_comb begin
        w_wdata = PIP_second_operand_i;
        case (PIP_mem_size_i)
            MEM_BYTE: w_wdata = {4{PIP_second_operand_i[7:0]}};
            MEM_HALF: w_wdata = {2{PIP_second_operand_i[15:0]}};
            default:  w_wdata = PIP_second_operand_i;
        endcase
    end

    assign dmem.req   = w_req;
    assign dmem.we    = PIP_write_mem_i;
    assign dmem.addr  = {PIP_alu_result_i[31:2], 2'b00};
    assign dmem.be    = reset_n ? lane_enables(PIP_alu_result_i[1:0], PIP_mem_size_i)
                                : 4'b0000;
    assign dmem.wdata = w_wdata;
    assign stall_o    = w_stall;

    load_aligner u_load_aligner (
        .rdata       (dmem.rdata),
        .addr_lo     (PIP_alu_result_i[1:0]),
        .size        (PIP_mem_size_i),
        .is_unsigned (PIP_mem_unsigned_i),
        .data        (w_load_data)
    );

    // FSM, wait counter and MEM/WB registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= MS_IDLE;
            r_wait_cnt   <= '0;
            r_alu_result <= '0;
            r_mem_data   <= '0;
            r_use_mem    <= 1'b0;
            r_write_reg  <= 1'b0;
            r_rd         <= '0;
            r_trap       <= 1'b0;
        end else if (w_stall) begin
            // Transfer outstanding: count the cycle, emit a bubble and keep
            // the data fields as they were.
            r_state     <= MS_WAIT;
            r_wait_cnt  <= r_wait_cnt + 1'b1;
            r_use_mem   <= 1'b0;
            r_write_reg <= 1'b0;
            r_trap      <= 1'b0;
        end else begin
            r_state      <= MS_IDLE;
            r_wait_cnt   <= '0;
            r_alu_result <= PIP_alu_result_i;
            r_rd         <= PIP_rd_i;
            if (w_fault) begin
                r_use_mem   <= 1'b0;
                r_write_reg <= 1'b0;
                r_trap      <= 1'b1;
            end else begin
                r_use_mem   <= PIP_use_mem_i;
                r_write_reg <= PIP_write_reg_i;
                r_trap      <= PIP_TRAP_i;
                if (PIP_read_mem_i & w_req & dmem.ack) begin
                    r_mem_data <= w_load_data;
                end
            end
        end
    end

    assign PIP_alu_result_o = r_alu_result;
    assign PIP_mem_data_o   = r_mem_data;
    assign PIP_use_mem_o    = r_use_mem;
    assign PIP_write_reg_o  = r_write_reg;
    assign PIP_rd_o         = r_rd;
    assign PIP_TRAP_o       = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_access
// Purpose  : Self-checking bench for memory_access: directed scenarios plus
//            randomized loads, stores and pass-through instructions against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_access;
    import memory_access_pkg::*;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        PIP_write_mem_i, PIP_read_mem_i;
    logic [31:0] PIP_alu_result_i, PIP_second_operand_i;
    logic [1:0]  PIP_mem_size_i;
    logic        PIP_mem_unsigned_i, PIP_use_mem_i, PIP_write_reg_i;
    logic [4:0]  PIP_rd_i;
    logic        PIP_TRAP_i;
    logic        stall_o;
    logic [31:0] PIP_alu_result_o, PIP_mem_data_o;
    logic        PIP_use_mem_o, PIP_write_reg_o;
    logic [4:0]  PIP_rd_o;
    logic        PIP_TRAP_o;

    memory_access_if dmem();

    memory_access #(.MAX_WAIT(MW)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .PIP_write_mem_i      (PIP_write_mem_i),
        .PIP_read_mem_i       (PIP_read_mem_i),
        .PIP_alu_result_i     (PIP_alu_result_i),
        .PIP_second_operand_i (PIP_second_operand_i),
        .PIP_mem_size_i       (PIP_mem_size_i),
        .PIP_mem_unsigned_i   (PIP_mem_unsigned_i),
        .PIP_use_mem_i        (PIP_use_mem_i),
        .PIP_write_reg_i      (PIP_write_reg_i),
        .PIP_rd_i             (PIP_rd_i),
        .PIP_TRAP_i           (PIP_TRAP_i),
        .dmem                 (dmem),
        .stall_o              (stall_o),
        .PIP_alu_result_o     (PIP_alu_result_o),
        .PIP_mem_data_o       (PIP_mem_data_o),
        .PIP_use_mem_o        (PIP_use_mem_o),
        .PIP_write_reg_o      (PIP_write_reg_o),
        .PIP_rd_o             (PIP_rd_o),
        .PIP_TRAP_o           (PIP_TRAP_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_mem_data = 32'h0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                               input int size, input bit uns);
        logic [31:0] v;
        v = rdata >> (8 * off);
        if (size == 0) begin
            v = v % 32'h100;
            if (!uns && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (size == 1) begin
            v = v % 32'h10000;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_be(input int off, input int size);
        if (size == 0) return 32'(1 << off);
        if (size == 1) return (off >= 2) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input int size);
        if (size == 0) return (rs2 % 32'h100) * 32'h01010101;
        if (size == 1) return (rs2 % 32'h10000) * 32'h00010001;
        return rs2;
    endfunction

    // One instruction through the stage. waits = no-ack cycles the memory
    // inserts before acking; called at posedge+1, returns at posedge+1.
    task automatic do_op(input bit we, input bit re, input logic [31:0] addr,
                         input logic [31:0] rs2, input int size, input bit uns,
                         input logic [31:0] rdata, input int waits);
        bit       access, mis, to, exp_req;
        int       last, off;
        bit       wr, um, tr;
        logic [4:0] rd;
        off    = int'(addr % 4);
        access = we | re;
        mis    = access && ((size == 1 && (off % 2) != 0) || (size == 2 && off != 0));
        to     = 1'b0;
        if (!access || mis) last = 0;
        else if (waits <= MW - 1) last = waits;
        else begin last = MW - 1; to = 1'b1; end
        wr = 1'($urandom % 2); um = 1'($urandom % 2);
        tr = ($urandom % 8) == 0; rd = 5'($urandom);

        PIP_write_mem_i      = we;
        PIP_read_mem_i       = re;
        PIP_alu_result_i     = addr;
        PIP_second_operand_i = rs2;
        PIP_mem_size_i       = 2'(size);
        PIP_mem_unsigned_i   = uns;
        PIP_use_mem_i        = um;
        PIP_write_reg_i      = wr;
        PIP_rd_i             = rd;
        PIP_TRAP_i           = tr;

        for (int k = 0; k <= last; k++) begin
            dmem.ack   = access && !mis && !to && (k == last);
            dmem.rdata = (k == last) ? rdata : $urandom;
            exp_req    = access && !mis && ((k < last) || !to);
            @(negedge clk);
            check_value("req", 32'(dmem.req), 32'(exp_req));
            check_value("stall", 32'(stall_o), 32'(access && !mis && k < last));
            if (exp_req) begin
                check_value("we", 32'(dmem.we), 32'(we));
                check_value("addr", dmem.addr, addr - 32'(off));
                check_value("be", 32'(dmem.be), model_be(off, size));
                if (we) check_value("wdata", dmem.wdata, model_wdata(rs2, size));
            end
            @(posedge clk); #1;
            if (k < last) begin
                check_value("bubble", {29'd0, PIP_write_reg_o, PIP_use_mem_o, PIP_TRAP_o}, 32'd0);
            end
        end
        dmem.ack = 1'b0;

        check_value("alu_out", PIP_alu_result_o, addr);
        if (access && (mis || to)) begin
            check_value("trap_flags", {29'd0, PIP_write_reg_o, PIP_use_mem_o, PIP_TRAP_o}, 32'd1);
        end else begin
            if (re) exp_mem_data = model_load(rdata, off, size, uns);
            check_value("wb_flags", {29'd0, PIP_write_reg_o, PIP_use_mem_o, PIP_TRAP_o},
                        {29'd0, wr, um, tr});
            check_value("rd_out", 32'(PIP_rd_o), 32'(rd));
        end
        check_value("mem_data", PIP_mem_data_o, exp_mem_data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        PIP_write_mem_i = 0; PIP_read_mem_i = 0; PIP_alu_result_i = 0;
        PIP_second_operand_i = 0; PIP_mem_size_i = 0; PIP_mem_unsigned_i = 0;
        PIP_use_mem_i = 0; PIP_write_reg_i = 0; PIP_rd_i = 0; PIP_TRAP_i = 0;
        dmem.ack = 0; dmem.rdata = 0;
        #2;
        check_value("rst_outputs", {PIP_alu_result_o ^ PIP_mem_data_o}, 32'd0);
        check_value("rst_ctrl", {24'd0, PIP_rd_o, PIP_write_reg_o, PIP_use_mem_o, PIP_TRAP_o}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios
        do_op(1, 0, 32'h100, 32'hDEADBEEF, 2, 0, 32'h0, 0);        // SW, zero wait
        do_op(0, 1, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 2);       // LB, 2 waits
        check_value("lb_value", PIP_mem_data_o, 32'hFFFFFF80);
        do_op(0, 1, 32'h103, 32'h0, 0, 1, 32'h80FF0000, 2);       // LBU
        check_value("lbu_value", PIP_mem_data_o, 32'h00000080);
        do_op(1, 0, 32'h102, 32'h1234, 1, 0, 32'h0, 1);           // SH
        do_op(0, 1, 32'h101, 32'h0, 1, 0, 32'h0, 0);              // LH misaligned
        check_value("lh_trap", 32'(PIP_TRAP_o), 32'd1);
        do_op(0, 1, 32'h200, 32'h0, 2, 0, 32'h11112222, 10);      // timeout
        do_op(0, 1, 32'h204, 32'h0, 2, 0, 32'hCAFEF00D, MW - 1);  // ack in last cycle
        check_value("late_ack", PIP_mem_data_o, 32'hCAFEF00D);
        do_op(0, 0, 32'h12345678, 32'h0, 2, 0, 32'h0, 0);         // pass-through

        // Reset during WAIT
        PIP_read_mem_i = 1; PIP_write_mem_i = 0; PIP_alu_result_i = 32'h40;
        PIP_mem_size_i = 2'd2; PIP_write_reg_i = 1; PIP_use_mem_i = 1;
        dmem.ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_value("rst_req_stall_be", {26'd0, dmem.be, dmem.req, stall_o}, 32'd0);
        check_value("rst_data", PIP_alu_result_o | PIP_mem_data_o, 32'd0);
        check_value("rst_flags", {24'd0, PIP_rd_o, PIP_write_reg_o, PIP_use_mem_o, PIP_TRAP_o}, 32'd0);
        exp_mem_data = 32'h0;
        PIP_read_mem_i = 0; PIP_write_reg_i = 0; PIP_use_mem_i = 0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        do_op(0, 1, 32'h44, 32'h0, 2, 0, 32'h5A5AA5A5, 1);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int kind, sz, w;
            logic [31:0] a;
            kind = int'($urandom % 3);
            sz   = int'($urandom % 3);
            a    = $urandom % 32'h1000;
            if (($urandom % 4) != 0) a = a - (a % (32'd1 << sz));
            w    = int'($urandom % 6);
            do_op(kind == 2, kind == 1, a, $urandom, sz, 1'($urandom % 2), $urandom, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
